// File: rtl/mbc1_cart_responder.sv
// MBC1 cartridge responder: decodes host bus cycles, maps ROM/RAM banks and
// serves reads from synchronous memories with a fixed two-clock read latency.
module mbc1_cart_responder #(
   parameter int unsigned ROM_AW = 21,
   parameter int unsigned RAM_AW = 15
) (
   input  logic              clk_8m,
   input  logic              rst,
   input  logic [15:0]       cart_a,
   input  logic [7:0]        cart_d_in,
   output logic [7:0]        cart_d_out,
   output logic              cart_d_oe,
   input  logic              cart_ncs,
   input  logic              cart_nrd,
   input  logic              cart_nwr,
   output logic [ROM_AW-1:0] rom_addr,
   output logic              rom_rd,
   input  logic [7:0]        rom_rdata,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_rd,
   output logic              ram_wr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata
);

   typedef enum logic [1:0] {StIdle, StRd, StHold} state_t;

   // Where RD-state data comes from; SrcNone leaves the bus undriven.
   typedef enum logic [1:0] {SrcRom, SrcRam, SrcFf, SrcNone} src_t;

   state_t     state;
   src_t       src;
   logic [4:0] bank1;
   logic [1:0] bank2;
   logic       mode;
   logic       ram_en;

   logic       strobe;
   logic       is_read;
   logic       is_write;
   logic       sel_rom;
   logic       sel_ram;
   logic       sel_high;
   logic       start;
   logic [1:0] hi_bank;
   logic [6:0] rom_bank;

   // Bus decode; a read wins when both strobes are low.
   always_comb begin
      strobe   = ~cart_ncs & (~cart_nrd | ~cart_nwr);
      is_read  = ~cart_nrd;
      is_write = cart_nrd & ~cart_nwr;
      sel_rom  = ~cart_a[15];
      sel_ram  = (cart_a[15:13] == 3'b101);
      sel_high = (cart_a[15:14] == 2'b11);
      start    = ~rst & (state == StIdle) & strobe;
   end

   // Bank mapping; bank2 only reaches the low ROM window and RAM in mode 1.
   always_comb begin
      hi_bank  = mode ? bank2 : 2'b00;
      rom_bank = cart_a[14] ? {bank2, bank1} : {hi_bank, 5'b00000};
      rom_addr = ROM_AW'({rom_bank, cart_a[13:0]});
      ram_addr = RAM_AW'({hi_bank, cart_a[12:0]});
   end

   // Memory requests are single-cycle pulses issued only from IDLE.
   always_comb begin
      rom_rd    = start & is_read & sel_rom;
      ram_rd    = start & is_read & sel_ram & ram_en;
      ram_wr    = start & is_write & sel_ram & ram_en;
      ram_wdata = cart_d_in;
   end

   // Access FSM, MBC1 register file and registered data-bus outputs.
   always_ff @(posedge clk_8m) begin
      if (rst) begin
         state      <= StIdle;
         src        <= SrcNone;
         bank1      <= 5'd1;
         bank2      <= 2'd0;
         mode       <= 1'b0;
         ram_en     <= 1'b0;
         cart_d_out <= 8'hFF;
         cart_d_oe  <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (strobe) begin
                  if (is_read) begin
                     state <= StRd;
                     if (sel_rom) begin
                        src <= SrcRom;
                     end else if (sel_ram) begin
                        src <= ram_en ? SrcRam : SrcFf;
                     end else if (sel_high) begin
                        src <= SrcNone;
                     end else begin
                        src <= SrcFf;
                     end
                  end else begin
                     // Write acts once here; HOLD absorbs the rest of the strobe.
                     state <= StHold;
                     if (sel_rom) begin
                        unique case (cart_a[14:13])
                           2'b00: ram_en <= (cart_d_in[3:0] == 4'hA);
                           2'b01: bank1  <= (cart_d_in[4:0] == 5'd0) ? 5'd1 : cart_d_in[4:0];
                           2'b10: bank2  <= cart_d_in[1:0];
                           2'b11: mode   <= cart_d_in[0];
                           default: ;
                        endcase
                     end
                  end
               end
            end
            StRd: begin
               if (!strobe) begin
                  // Host gave up early: capture nothing.
                  state <= StIdle;
               end else begin
                  state     <= StHold;
                  cart_d_oe <= (src != SrcNone);
                  case (src)
                     SrcRom:  cart_d_out <= rom_rdata;
                     SrcRam:  cart_d_out <= ram_rdata;
                     default: cart_d_out <= 8'hFF;
                  endcase
               end
            end
            StHold: begin
               if (!strobe) begin
                  state     <= StIdle;
                  cart_d_oe <= 1'b0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mbc1_cart_responder.sv
// Directed bench for mbc1_cart_responder with behavioural ROM/RAM models.
module tb_mbc1_cart_responder;

   logic        clk_8m = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cart_a = 16'h0000;
   logic [7:0]  cart_d_in = 8'h00;
   logic [7:0]  cart_d_out;
   logic        cart_d_oe;
   logic        cart_ncs = 1'b1;
   logic        cart_nrd = 1'b1;
   logic        cart_nwr = 1'b1;
   logic [20:0] rom_addr;
   logic        rom_rd;
   logic [7:0]  rom_rdata = 8'h00;
   logic [14:0] ram_addr;
   logic        ram_rd;
   logic        ram_wr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = 8'h00;

   logic [7:0]  ram_mem [0:32767];

   int n_checks = 0;
   int n_errors = 0;
   int rom_rd_cnt = 0;
   int ram_rd_cnt = 0;
   int ram_wr_cnt = 0;
   logic [20:0] last_rom_addr = '0;
   logic [14:0] last_ram_addr = '0;
   logic [7:0]  last_ram_wdata = '0;

   mbc1_cart_responder #(
      .ROM_AW(21),
      .RAM_AW(15)
   ) dut (
      .clk_8m     (clk_8m),
      .rst        (rst),
      .cart_a     (cart_a),
      .cart_d_in  (cart_d_in),
      .cart_d_out (cart_d_out),
      .cart_d_oe  (cart_d_oe),
      .cart_ncs   (cart_ncs),
      .cart_nrd   (cart_nrd),
      .cart_nwr   (cart_nwr),
      .rom_addr   (rom_addr),
      .rom_rd     (rom_rd),
      .rom_rdata  (rom_rdata),
      .ram_addr   (ram_addr),
      .ram_rd     (ram_rd),
      .ram_wr     (ram_wr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   always #62 clk_8m = ~clk_8m;

   // ROM content is addr[7:0] ^ 5A; RAM is a plain byte array.
   always @(posedge clk_8m) begin
      if (rom_rd) begin
         rom_rdata <= rom_addr[7:0] ^ 8'h5A;
         rom_rd_cnt++;
         last_rom_addr = rom_addr;
      end
      if (ram_rd) begin
         ram_rdata <= ram_mem[ram_addr];
         ram_rd_cnt++;
      end
      if (ram_wr) begin
         ram_mem[ram_addr] <= ram_wdata;
         ram_wr_cnt++;
         last_ram_addr = ram_addr;
         last_ram_wdata = ram_wdata;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Full host read: strobe after E0, sample after E2, release at E3.
   task automatic bus_read(input logic [15:0] addr, input logic both,
                           output logic [7:0] dout, output logic oe_data,
                           output logic oe_after);
      @(posedge clk_8m); #1;
      cart_a = addr; cart_ncs = 1'b0; cart_nrd = 1'b0; cart_nwr = ~both;
      @(posedge clk_8m);
      @(posedge clk_8m);
      @(negedge clk_8m);
      dout = cart_d_out; oe_data = cart_d_oe;
      @(posedge clk_8m); #1;
      cart_ncs = 1'b1; cart_nrd = 1'b1; cart_nwr = 1'b1;
      @(posedge clk_8m);
      @(negedge clk_8m);
      oe_after = cart_d_oe;
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
      @(posedge clk_8m); #1;
      cart_a = addr; cart_d_in = data; cart_ncs = 1'b0; cart_nwr = 1'b0;
      repeat (hold) @(posedge clk_8m);
      #1;
      cart_ncs = 1'b1; cart_nwr = 1'b1;
      @(posedge clk_8m);
   endtask

   initial begin
      logic [7:0] d;
      logic       oe, oe2;
      int         c0;

      repeat (3) @(posedge clk_8m);
      @(negedge clk_8m);
      check_eq("reset_dout", {24'h0, cart_d_out}, 32'hFF);
      check_eq("reset_oe", {31'h0, cart_d_oe}, 32'h0);
      check_eq("reset_req", {29'h0, rom_rd, ram_rd, ram_wr}, 32'h0);
      @(posedge clk_8m); #1;
      rst = 1'b0;

      // Basic ROM read from bank 1 window.
      c0 = rom_rd_cnt;
      bus_read(16'h4000, 1'b0, d, oe, oe2);
      check_eq("rd4000_addr", {11'h0, last_rom_addr}, 32'h004000);
      check_eq("rd4000_pulses", rom_rd_cnt - c0, 1);
      check_eq("rd4000_dout", {24'h0, d}, 32'h5A);
      check_eq("rd4000_oe", {31'h0, oe}, 32'h1);
      check_eq("rd4000_oe_rel", {31'h0, oe2}, 32'h0);

      // Bank 0 written as 1, then full bank field.
      bus_write(16'h2000, 8'h00, 3);
      bus_read(16'h4123, 1'b0, d, oe, oe2);
      check_eq("bank0as1_addr", {11'h0, last_rom_addr}, 32'h004123);
      check_eq("bank0as1_dout", {24'h0, d}, 32'h79);
      bus_write(16'h2000, 8'h1F, 3);
      bus_write(16'h4000, 8'h03, 3);
      bus_read(16'h7FFF, 1'b0, d, oe, oe2);
      check_eq("rd7fff_addr", {11'h0, last_rom_addr}, 32'h1FFFFF);
      check_eq("rd7fff_dout", {24'h0, d}, 32'hA5);

      // Mode affects the low ROM window.
      bus_write(16'h4000, 8'h02, 3);
      bus_read(16'h0010, 1'b0, d, oe, oe2);
      check_eq("mode0_addr", {11'h0, last_rom_addr}, 32'h000010);
      bus_write(16'h6000, 8'h01, 3);
      bus_read(16'h0010, 1'b0, d, oe, oe2);
      check_eq("mode1_addr", {11'h0, last_rom_addr}, 32'h100010);
      check_eq("mode1_dout", {24'h0, d}, 32'h4A);

      // RAM disabled: no write, no read request, FF on the bus.
      c0 = ram_wr_cnt;
      bus_write(16'hA000, 8'h77, 3);
      check_eq("ramdis_wr", ram_wr_cnt - c0, 0);
      c0 = ram_rd_cnt;
      bus_read(16'hA000, 1'b0, d, oe, oe2);
      check_eq("ramdis_rd", ram_rd_cnt - c0, 0);
      check_eq("ramdis_dout", {24'h0, d}, 32'hFF);
      check_eq("ramdis_oe", {31'h0, oe}, 32'h1);

      // RAM enabled, bank 1 in mode 1.
      bus_write(16'h0000, 8'h0A, 3);
      bus_write(16'h4000, 8'h01, 3);
      bus_write(16'h6000, 8'h01, 3);
      c0 = ram_wr_cnt;
      bus_write(16'hA005, 8'h77, 3);
      check_eq("ramwr_pulses", ram_wr_cnt - c0, 1);
      check_eq("ramwr_addr", {17'h0, last_ram_addr}, 32'h2005);
      check_eq("ramwr_data", {24'h0, last_ram_wdata}, 32'h77);
      c0 = ram_rd_cnt;
      bus_read(16'hA005, 1'b0, d, oe, oe2);
      check_eq("ramrd_pulses", ram_rd_cnt - c0, 1);
      check_eq("ramrd_dout", {24'h0, d}, 32'h77);

      // Long write strobe still gives one pulse.
      c0 = ram_wr_cnt;
      bus_write(16'hA006, 8'h33, 10);
      check_eq("longwr_pulses", ram_wr_cnt - c0, 1);

      // C000 region: bus stays undriven.
      c0 = rom_rd_cnt;
      bus_read(16'hC000, 1'b0, d, oe, oe2);
      check_eq("c000_oe", {31'h0, oe}, 32'h0);
      check_eq("c000_dout", {24'h0, d}, 32'hFF);
      check_eq("c000_norom", rom_rd_cnt - c0, 0);

      // Both strobes low at 2000 is a read; bank1 must stay 1F.
      cart_d_in = 8'h05;
      bus_read(16'h2000, 1'b1, d, oe, oe2);
      check_eq("both_addr", {11'h0, last_rom_addr}, 32'h082000);
      check_eq("both_dout", {24'h0, d}, 32'h5A);
      bus_read(16'h4000, 1'b0, d, oe, oe2);
      check_eq("both_bank1", {11'h0, last_rom_addr}, 32'h0FC000);

      // Early release in RD: nothing driven.
      @(posedge clk_8m); #1;
      cart_a = 16'h4001; cart_ncs = 1'b0; cart_nrd = 1'b0;
      @(posedge clk_8m); #1;
      cart_ncs = 1'b1; cart_nrd = 1'b1;
      @(posedge clk_8m);
      @(negedge clk_8m);
      check_eq("early_oe", {31'h0, cart_d_oe}, 32'h0);
      @(posedge clk_8m);

      // Reset while in RD.
      @(posedge clk_8m); #1;
      cart_a = 16'h4000; cart_ncs = 1'b0; cart_nrd = 1'b0;
      @(posedge clk_8m); #1;
      rst = 1'b1;
      @(posedge clk_8m);
      @(negedge clk_8m);
      check_eq("rstrd_oe", {31'h0, cart_d_oe}, 32'h0);
      check_eq("rstrd_dout", {24'h0, cart_d_out}, 32'hFF);
      check_eq("rstrd_romrd", {31'h0, rom_rd}, 32'h0);
      @(posedge clk_8m); #1;
      rst = 1'b0; cart_ncs = 1'b1; cart_nrd = 1'b1;
      bus_read(16'h4000, 1'b0, d, oe, oe2);
      check_eq("rstrd_bank", {11'h0, last_rom_addr}, 32'h004000);
      check_eq("rstrd_dout2", {24'h0, d}, 32'h5A);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
